// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt source conditioner and the controller's
// priority decode.
package irq_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 2;

  localparam logic [ADDR_W-1:0] IRQ_PEND = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IRQ_MASK = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IRQ_MODE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IRQ_CTRL = ADDR_W'(3);

  // One-hot of the lowest set bit; bit 0 is the highest priority.
  function automatic logic [NUM_IRQ-1:0] prio_lsb(input logic [NUM_IRQ-1:0] req);
    return req & (~req + NUM_IRQ'(1));
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-bit multi-stage flop synchroniser for asynchronous request lines.
module irq_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/irq_capture.sv
// Interrupt source conditioner: synchronises request lines, applies polarity and
// edge/level selection, latches edge pendings and exposes a small register file.
module irq_capture #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   irq_active,
  input  logic [1:0]             addr,
  input  logic [2*NUM_IRQ-1:0]   wdata,
  input  logic                   we,
  input  logic                   re,
  output logic [2*NUM_IRQ-1:0]   rdata,
  output logic [NUM_IRQ-1:0]     interrupts,
  output logic [2*NUM_IRQ-1:0]   conf
);

  import irq_pkg::*;

  logic [NUM_IRQ-1:0] sync_c;
  logic [NUM_IRQ-1:0] s_c;
  logic [NUM_IRQ-1:0] s_prev_q;
  logic [NUM_IRQ-1:0] set_c;
  logic [NUM_IRQ-1:0] ack_clr_c;
  logic [NUM_IRQ-1:0] w1c_pend_c;
  logic [NUM_IRQ-1:0] w1c_ovf_c;
  logic [NUM_IRQ-1:0] edge_nxt_c;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] ovf_q;
  logic [NUM_IRQ-1:0] ovf_d;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pol_q;
  logic [NUM_IRQ-1:0] edge_sel_q;
  logic               act_q;
  logic               ack_c;
  logic               wr_pend_c;
  logic               wr_mask_c;
  logic               wr_mode_c;
  logic               wr_ctrl_c;
  logic [2*NUM_IRQ-1:0] rdata_c;

  irq_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (irq_in),
    .q   (sync_c)
  );

  assign wr_pend_c = we && (addr == IRQ_PEND);
  assign wr_mask_c = we && (addr == IRQ_MASK);
  assign wr_mode_c = we && (addr == IRQ_MODE);
  assign wr_ctrl_c = we && (addr == IRQ_CTRL);

  // Conditioning, edge detect, ack and W1C; a new edge set wins over any clear.
  always_comb begin
    s_c        = sync_c ^ pol_q;
    set_c      = s_c & ~s_prev_q & edge_sel_q;
    ack_c      = irq_active & ~act_q;
    ack_clr_c  = '0;
    w1c_pend_c = '0;
    w1c_ovf_c  = '0;
    edge_nxt_c = edge_sel_q;
    if (ack_c) begin
      // Only an edge line can be acknowledged; a level winner clears nothing.
      ack_clr_c = prio_lsb(interrupts & mask_q) & edge_sel_q;
    end
    if (wr_pend_c) begin
      w1c_pend_c = wdata[NUM_IRQ-1:0];
      w1c_ovf_c  = wdata[2*NUM_IRQ-1:NUM_IRQ];
    end
    if (wr_ctrl_c) begin
      edge_nxt_c = wdata[NUM_IRQ-1:0];
    end
    pend_d = ((pend_q & ~(ack_clr_c | w1c_pend_c)) | set_c) & edge_nxt_c;
    ovf_d  = (ovf_q & ~w1c_ovf_c) | (set_c & pend_q);
    irq_d  = (pend_d & edge_nxt_c) | (s_c & ~edge_nxt_c);
  end

  // Read mux samples pre-write state so a simultaneous write is not visible yet.
  always_comb begin
    rdata_c = '0;
    case (addr)
      IRQ_PEND: rdata_c = {ovf_q, interrupts};
      IRQ_MASK: rdata_c = {NUM_IRQ'(0), mask_q};
      IRQ_MODE: rdata_c = {NUM_IRQ'(0), mode_q};
      IRQ_CTRL: rdata_c = {pol_q, edge_sel_q};
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_prev_q   <= '0;
      act_q      <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= '0;
      interrupts <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      pol_q      <= '0;
      edge_sel_q <= '0;
      rdata      <= '0;
    end else begin
      s_prev_q   <= s_c;
      act_q      <= irq_active;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      interrupts <= irq_d;
      if (wr_mask_c) begin
        mask_q <= wdata[NUM_IRQ-1:0];
      end
      if (wr_mode_c) begin
        mode_q <= wdata[NUM_IRQ-1:0];
      end
      if (wr_ctrl_c) begin
        edge_sel_q <= wdata[NUM_IRQ-1:0];
        pol_q      <= wdata[2*NUM_IRQ-1:NUM_IRQ];
      end
      if (re) begin
        rdata <= rdata_c;
      end
    end
  end

  assign conf = {mode_q, mask_q};

endmodule

// File: tb/tb_irq_capture.sv
// Directed self-checking bench for irq_capture: level/edge paths, ack, polarity,
// overflow, W1C priority, register access and asynchronous reset.
module tb_irq_capture;

  logic        CLK;
  logic        RST;
  logic [7:0]  irq_in;
  logic        irq_active;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        we;
  logic        re;
  logic [15:0] rdata;
  logic [7:0]  interrupts;
  logic [15:0] conf;

  int n_checks = 0;
  int n_fail   = 0;

  irq_capture #(
    .NUM_IRQ     (8),
    .SYNC_STAGES (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .irq_in     (irq_in),
    .irq_active (irq_active),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .re         (re),
    .rdata      (rdata),
    .interrupts (interrupts),
    .conf       (conf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    wdata = 16'h0000;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
  endtask

  task automatic apply_reset();
    irq_in     = 8'h00;
    irq_active = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    addr       = 2'd0;
    wdata      = 16'h0000;
    RST        = 1'b1;
    tick();
    RST        = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_interrupts: got %h expected %h", interrupts, 8'h00);
    end
    n_checks++;
    if (conf !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_conf: got %h expected %h", conf, 16'h0000);
    end
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected %h", rdata, 16'h0000);
    end
    rd(2'd3);
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_ctrl_read: got %h expected %h", rdata, 16'h0000);
    end
  endtask

  task automatic test_level();
    apply_reset();
    irq_in = 8'h08;
    tick(2);
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL level_latency: got %h expected %h", interrupts, 8'h00);
    end
    tick();
    n_checks++;
    if (interrupts !== 8'h08) begin
      n_fail++;
      $display("FAIL level_on: got %h expected %h", interrupts, 8'h08);
    end
    irq_in = 8'h00;
    tick(3);
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL level_off: got %h expected %h", interrupts, 8'h00);
    end
  endtask

  task automatic test_edge_ack();
    apply_reset();
    wr(2'd3, 16'h0005);
    wr(2'd1, 16'h0005);
    n_checks++;
    if (conf !== 16'h0005) begin
      n_fail++;
      $display("FAIL edge_conf: got %h expected %h", conf, 16'h0005);
    end
    irq_in = 8'h05;
    tick(3);
    irq_in = 8'h00;
    tick(4);
    n_checks++;
    if (interrupts !== 8'h05) begin
      n_fail++;
      $display("FAIL edge_latched: got %h expected %h", interrupts, 8'h05);
    end
    irq_active = 1'b1;
    tick();
    n_checks++;
    if (interrupts !== 8'h04) begin
      n_fail++;
      $display("FAIL ack_first: got %h expected %h", interrupts, 8'h04);
    end
    tick(2);
    n_checks++;
    if (interrupts !== 8'h04) begin
      n_fail++;
      $display("FAIL ack_held_high: got %h expected %h", interrupts, 8'h04);
    end
    irq_active = 1'b0;
    tick();
    irq_active = 1'b1;
    tick();
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL ack_second: got %h expected %h", interrupts, 8'h00);
    end
    irq_active = 1'b0;
    tick();
  endtask

  task automatic test_polarity();
    apply_reset();
    irq_in = 8'h02;
    tick(3);
    wr(2'd3, 16'h0202);
    tick(3);
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL pol_idle: got %h expected %h", interrupts, 8'h00);
    end
    irq_in = 8'h00;
    tick(3);
    n_checks++;
    if (interrupts !== 8'h02) begin
      n_fail++;
      $display("FAIL pol_edge: got %h expected %h", interrupts, 8'h02);
    end
    rd(2'd0);
    n_checks++;
    if (rdata !== 16'h0002) begin
      n_fail++;
      $display("FAIL pol_pend_read: got %h expected %h", rdata, 16'h0002);
    end
  endtask

  task automatic test_overflow_w1c();
    apply_reset();
    wr(2'd3, 16'h0010);
    for (int k = 0; k < 2; k++) begin
      irq_in = 8'h10;
      tick(3);
      irq_in = 8'h00;
      tick(3);
    end
    rd(2'd0);
    n_checks++;
    if (rdata !== 16'h1010) begin
      n_fail++;
      $display("FAIL ovf_read: got %h expected %h", rdata, 16'h1010);
    end
    wr(2'd0, 16'h1010);
    rd(2'd0);
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL ovf_w1c_read: got %h expected %h", rdata, 16'h0000);
    end
  endtask

  task automatic test_set_beats_clear();
    apply_reset();
    wr(2'd3, 16'h0001);
    irq_in = 8'h01;
    tick(3);
    irq_in = 8'h00;
    tick(3);
    n_checks++;
    if (interrupts !== 8'h01) begin
      n_fail++;
      $display("FAIL sbc_first_edge: got %h expected %h", interrupts, 8'h01);
    end
    irq_in = 8'h01;
    tick(2);
    wr(2'd0, 16'h0001);
    n_checks++;
    if (interrupts !== 8'h01) begin
      n_fail++;
      $display("FAIL set_beats_clear: got %h expected %h", interrupts, 8'h01);
    end
    irq_in = 8'h00;
    tick(3);
    rd(2'd0);
    n_checks++;
    if (rdata !== 16'h0101) begin
      n_fail++;
      $display("FAIL sbc_pend_ovf: got %h expected %h", rdata, 16'h0101);
    end
    wr(2'd0, 16'h0101);
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL w1c_alone: got %h expected %h", interrupts, 8'h00);
    end
  endtask

  task automatic test_regs();
    apply_reset();
    wr(2'd1, 16'hFFFF);
    rd(2'd1);
    n_checks++;
    if (rdata !== 16'h00FF) begin
      n_fail++;
      $display("FAIL mask_upper_zero: got %h expected %h", rdata, 16'h00FF);
    end
    addr  = 2'd1;
    wdata = 16'h0033;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we    = 1'b0;
    re    = 1'b0;
    n_checks++;
    if (rdata !== 16'h00FF) begin
      n_fail++;
      $display("FAIL rw_prewrite: got %h expected %h", rdata, 16'h00FF);
    end
    n_checks++;
    if (conf !== 16'h0033) begin
      n_fail++;
      $display("FAIL rw_conf: got %h expected %h", conf, 16'h0033);
    end
    wr(2'd2, 16'hA5A5);
    n_checks++;
    if (conf !== 16'hA533) begin
      n_fail++;
      $display("FAIL mode_conf: got %h expected %h", conf, 16'hA533);
    end
    rd(2'd2);
    n_checks++;
    if (rdata !== 16'h00A5) begin
      n_fail++;
      $display("FAIL mode_read: got %h expected %h", rdata, 16'h00A5);
    end
    wr(2'd3, 16'hBEEF);
    rd(2'd3);
    n_checks++;
    if (rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL ctrl_read: got %h expected %h", rdata, 16'hBEEF);
    end
    tick(2);
    n_checks++;
    if (rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h expected %h", rdata, 16'hBEEF);
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    wr(2'd3, 16'h00FF);
    wr(2'd1, 16'h00FF);
    irq_in = 8'hFF;
    tick(3);
    irq_in = 8'h00;
    tick(3);
    n_checks++;
    if (interrupts !== 8'hFF) begin
      n_fail++;
      $display("FAIL rmo_pend_all: got %h expected %h", interrupts, 8'hFF);
    end
    rd(2'd1);
    RST = 1'b1;
    #1;
    n_checks++;
    if (interrupts !== 8'h00) begin
      n_fail++;
      $display("FAIL rmo_interrupts: got %h expected %h", interrupts, 8'h00);
    end
    n_checks++;
    if (conf !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmo_conf: got %h expected %h", conf, 16'h0000);
    end
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmo_rdata: got %h expected %h", rdata, 16'h0000);
    end
    tick();
    RST = 1'b0;
    tick(3);
    rd(2'd0);
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmo_pend_read: got %h expected %h", rdata, 16'h0000);
    end
  endtask

  initial begin
    RST        = 1'b1;
    irq_in     = 8'h00;
    irq_active = 1'b0;
    addr       = 2'd0;
    wdata      = 16'h0000;
    we         = 1'b0;
    re         = 1'b0;
    test_reset();
    test_level();
    test_edge_ack();
    test_polarity();
    test_overflow_w1c();
    test_set_beats_clear();
    test_regs();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
